// File: rtl/mem_pkg.sv
// mem_pkg: CPU MemOp encodings, responder state type and op legality helper
package mem_pkg;
  typedef logic [2:0] memop_t;
  localparam memop_t MEMOP_B  = 3'b000;
  localparam memop_t MEMOP_H  = 3'b001;
  localparam memop_t MEMOP_W  = 3'b010;
  localparam memop_t MEMOP_BU = 3'b100;
  localparam memop_t MEMOP_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  function automatic logic memop_legal(input memop_t op, input logic we);
    return (op inside {MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU}) && !(we && op[2]);
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane steering for stores and extension for loads
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  memop_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wword_o,
  output logic [3:0]  lane_en_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o,
  output logic        illegal_o
);
  logic [31:0] wrep;
  logic [31:0] sh;
  logic        sx;
  always_comb begin
    wrep = memop_i[1] ? wdata_i : memop_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    lane_en_o = memop_i[1] ? 4'hf : memop_i[0] ? (addr_i[1] ? 4'hc : 4'h3) : 4'b0001 << addr_i;
    sh = rword_i >> {addr_i, 3'b000};
    sx = ~memop_i[2];
    ldata_o = memop_i[1] ? rword_i
            : memop_i[0] ? {{16{sx & sh[15]}}, sh[15:0]} : {{24{sx & sh[7]}}, sh[7:0]};
    misalign_o = memop_i[1] ? |addr_i : memop_i[0] & addr_i[0];
    illegal_o = ~memop_legal(memop_i, we_i);
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wword_o[8*i +: 8] = lane_en_o[i] ? wrep[8*i +: 8] : rword_i[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: req/ack data-memory target with wait states, load extension and error reporting
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  memop,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  dmem_state_t     state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      memop_q;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            cur_we;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [2:0]      cur_op;
  logic [AW-1:0]   idx;
  logic            go;
  logic            err_d;
  logic [31:0]     wword;
  logic [31:0]     ldata;
  logic [3:0]      lane_en;
  logic            misalign;
  logic            illegal;
  // Zero-wait requests commit on the accepting edge, so IDLE works on the live inputs
  always_comb begin
    cur_we = state_q == IDLE ? we : we_q;
    cur_addr = state_q == IDLE ? addr : addr_q;
    cur_wdata = state_q == IDLE ? wdata : wdata_q;
    cur_op = state_q == IDLE ? memop : memop_q;
    idx = cur_addr[AW+1:2];
    go = state_q == IDLE ? req && WAIT_CYCLES == 0 : state_q == WAIT && cnt_q == 4'd0;
    err_d = illegal | misalign | ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
  end
  mem_lane_unit u_lane (
    .addr_i    (cur_addr[1:0]),
    .memop_i   (cur_op),
    .we_i      (cur_we),
    .wdata_i   (cur_wdata),
    .rword_i   (mem_q[idx]),
    .wword_o   (wword),
    .lane_en_o (lane_en),
    .ldata_o   (ldata),
    .misalign_o(misalign),
    .illegal_o (illegal)
  );
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (go && cur_we && !err_d && lane_en[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      memop_q <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      busy <= 1'b0;
    end else begin
      ack <= go;
      err <= go & err_d;
      rdata <= go && !err_d && !cur_we ? ldata : '0;
      case (state_q)
        IDLE: if (req) begin
          we_q <= we;
          addr_q <= addr;
          wdata_q <= wdata;
          memop_q <= memop;
          busy <= 1'b1;
          cnt_q <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          state_q <= WAIT_CYCLES > 0 ? WAIT : RESP;
        end
        WAIT: if (cnt_q == 4'd0) state_q <= RESP; else cnt_q <= cnt_q - 4'd1;
        RESP: begin
          state_q <= IDLE;
          busy <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for zero-wait and three-wait responders against a byte-level memory model
module tb_dmem_responder;
  localparam int DW = 64;
  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we, ack, err, busy;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [2:0]  memop [2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mb [2][DW*4];
  int          last_acc [2];
  bit          last_hold [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .memop(memop[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );
  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .memop(memop[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );
  function automatic int wc(input int d);
    return d == 1 ? 3 : 0;
  endfunction
  task automatic chk(input string n, input int d, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", n, d, a, e);
    end
  endtask
  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] op, output logic [31:0] rd, output logic er);
    int sz;
    bit legal;
    logic [31:0] v;
    sz = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : 4;
    legal = (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(w && op[2]);
    er = !legal || (a % sz != 0) || (a / 4 >= DW);
    rd = '0;
    v = '0;
    if (!er) begin
      for (int i = 0; i < sz; i++)
        if (w) mb[d][int'(a) + i] = wd[8*i +: 8];
        else v[8*i +: 8] = mb[d][int'(a) + i];
      if (!w) rd = op == 3'd0 ? {{24{v[7]}}, v[7:0]} : op == 3'd1 ? {{16{v[15]}}, v[15:0]} : v;
    end
  endtask
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] op, input bit hold, input bit live);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (busy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_req", d, 32'(busy[d]), 0);
    if (last_hold[d]) chk("throughput", d, 32'(cyc - last_acc[d]), 32'(wc(d) + 2));
    req[d] = 1'b1;
    we[d] = w;
    addr[d] = a;
    wdata[d] = wd;
    memop[d] = op;
    last_acc[d] = cyc;
    last_hold[d] = hold;
    if (live) begin
      model(d, w, a, wd, op, e.rd, e.er);
      e.due = cyc + 1 + wc(d);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req[d] = hold;
    we[d] = 1'($urandom);
    addr[d] = $urandom;
    wdata[d] = $urandom;
    memop[d] = 3'($urandom);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack dut%0d: got ack with no request outstanding", d);
        end else begin
          e = d == 0 ? q0.pop_front() : q1.pop_front();
          chk("rdata", d, rdata[d], e.rd);
          chk("err", d, 32'(err[d]), 32'(e.er));
          chk("ack_latency", d, 32'(cyc), 32'(e.due));
          chk("busy_in_ack", d, 32'(busy[d]), 1);
        end
      end
    end
  end
  initial begin
    logic [2:0] op;
    logic [31:0] a;
    bit h;
    req = '0;
    we = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0;
      wdata[d] = '0;
      memop[d] = '0;
      last_hold[d] = 0;
      last_acc[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 0);
      chk("rst_err", d, 32'(err[d]), 0);
      chk("rst_rdata", d, rdata[d], 0);
      chk("rst_busy", d, 32'(busy[d]), 0);
    end
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DW; w++) issue(d, 1'b1, 32'(w * 4), $urandom, 3'b010, 0, 1);
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1);
    issue(0, 1'b0, 32'h13, 32'h0, 3'b000, 0, 1);
    issue(0, 1'b0, 32'h13, 32'h0, 3'b100, 0, 1);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b001, 0, 1);
    issue(0, 1'b0, 32'h12, 32'h0, 3'b101, 0, 1);
    issue(0, 1'b1, 32'h11, 32'h12345678, 3'b000, 0, 1);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1);
    issue(0, 1'b1, 32'h12, 32'hAAAA5555, 3'b001, 0, 1);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1);
    issue(0, 1'b0, 32'h02, 32'h0, 3'b010, 0, 1);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b011, 0, 1);
    issue(0, 1'b1, 32'(DW * 4), 32'hCAFEF00D, 3'b010, 0, 1);
    issue(0, 1'b0, 32'h0, 32'h0, 3'b010, 0, 1);
    issue(1, 1'b1, 32'h40, 32'h89ABCDEF, 3'b010, 1, 1);
    issue(1, 1'b0, 32'h40, 32'h0, 3'b010, 1, 1);
    issue(1, 1'b0, 32'h42, 32'h0, 3'b000, 0, 1);
    issue(1, 1'b0, 32'h20, 32'h0, 3'b010, 0, 1);
    issue(1, 1'b1, 32'h20, 32'h11111111, 3'b010, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 1, 32'(ack[1]), 0);
    chk("midrst_err", 1, 32'(err[1]), 0);
    chk("midrst_rdata", 1, rdata[1], 0);
    chk("midrst_busy", 1, 32'(busy[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1'b0, 32'h20, 32'h0, 3'b010, 0, 1);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 150; k++) begin
        op = 3'($urandom);
        a = $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, DW * 4 + 8);
        h = k < 149 && $urandom_range(0, 1) == 1;
        issue(d, 1'($urandom), a, $urandom, op, h, 1);
      end
    repeat (10) @(negedge clk);
    chk("drain_q0", 0, 32'(q0.size()), 0);
    chk("drain_q1", 1, 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the CPU's load/store port. It accepts one request at a time over a req/ack handshake and serves byte, half-word and word accesses using the same MemOp encoding the CPU core drives. It adds configurable wait states, sign/zero extension of loads and error reporting. It sits between the CPU data port and the on-chip data RAM, and is the target for the multi-cycle core.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the internal RAM. Must be a power of two.
- `WAIT_CYCLES`, default 0: extra wait-state cycles inserted before each response. Legal range 0..15.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request valid. Sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from the low bytes for `sb`/`sh`.
- `memop` in 3: access type, with the same encoding as the CPU's `MemOp`.
- `rdata` out 32: load result. Valid only while `ack`=1.
- `ack` out 1: one-cycle response pulse.
- `err` out 1: error qualifier. Meaningful only while `ack`=1.
- `busy` out 1: high from the cycle after acceptance through the `ack` cycle.

## Operation
- **MemOp encoding:**
  - 000 = byte, signed
  - 001 = half, signed
  - 010 = word
  - 100 = byte, unsigned
  - 101 = half, unsigned
  - 011, 110 and 111 are illegal.
  - Stores use 000/001/010. Stores with 100 or 101 are illegal.
- **State machine:** IDLE, WAIT, RESP.
  - IDLE: if `req`=1, capture `we`, `addr`, `wdata` and `memop` into request registers. Go to WAIT if `WAIT_CYCLES`>0, else go to RESP.
  - WAIT: a down-counter is loaded with `WAIT_CYCLES`-1 at acceptance. When it reaches 0, go to RESP.
  - RESP: `ack`=1 for exactly one cycle, then return to IDLE.
- While `busy`=1, all inputs are ignored.
- **Error checks** (evaluated on the captured request):
  - illegal memop
  - misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠0
  - out-of-range address: `addr[31:2]` ≥ `DEPTH_WORDS`
- **On error:**
  - `err`=1, `rdata`=0.
  - RAM is not modified.
- **Store:**
  - Byte-lane write into word `addr[log2(DEPTH_WORDS)+1:2]`, lanes selected by `addr[1:0]`.
  - `sb` writes lane `addr[1:0]` with `wdata[7:0]`.
  - `sh` writes lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]`, little-endian.
  - `sw` writes all four lanes.
  - Unwritten lanes are preserved.
- **Load:**
  - Select the byte or half from the word by address, little-endian.
  - Sign-extend for 000/001, zero-extend for 100/101.
  - `rdata` for a store response is 0.
- **Reset:**
  - Outputs: `ack`=0, `err`=0, `rdata`=0, `busy`=0.
  - State: IDLE, counter 0.
  - RAM contents are not reset.
  - Reset asserted mid-request drops the request. An uncommitted store is never written.

## Timing
- **Latency:** acceptance edge E. `ack` is high during cycle E+1+`WAIT_CYCLES`.
  - With `WAIT_CYCLES`=0, `ack` is high in the cycle directly after the accepting edge.
- **Store commit:** the RAM write happens at the rising edge that enters RESP. A load accepted after that `ack` sees the new data.
- **Load read:** the RAM is read on the edge that enters RESP (registered read), so `rdata` is stable throughout the `ack` cycle.
- **Throughput:** the earliest next acceptance is the IDLE cycle after `ack`. If `req` is held high, the next request is accepted at the edge ending that IDLE cycle. One transaction completes per `WAIT_CYCLES`+2 cycles.
- **Registered outputs:** `rdata`, `ack`, `err` and `busy` are all driven from flops. No combinational path exists from inputs to outputs.

## Structure
- **Package `mem_pkg`:**
  - `memop_t` constants: `MEMOP_B`, `MEMOP_H`, `MEMOP_W`, `MEMOP_BU`, `MEMOP_HU`
  - `dmem_state_t` enum: IDLE, WAIT, RESP
- **Sub-module `mem_lane_unit`:** combinational.
  - Inputs: `addr[1:0]`, memop, wdata, current RAM word.
  - Outputs: merged write word, 4-bit lane enable, extended load value, misalign/illegal flags.
- **Top:** FSM, wait counter, request registers and the RAM array. RAM is a `logic [31:0]` array with per-lane writes.

## Test plan
- **Word write/read, `WAIT_CYCLES`=0:**
  - Store `sw` 0xDEADBEEF at 0x10, then load `lw` at 0x10.
  - Required: each `ack` one cycle after acceptance; `rdata`=0xDEADBEEF; `err`=0.
- **Byte/half extension:** after the word above:
  - `lb` at 0x13 → 0xFFFFFFDE
  - `lbu` at 0x13 → 0x000000DE
  - `lh` at 0x10 → 0xFFFFBEEF
  - `lhu` at 0x12 → 0x0000DEAD
- **Partial store:** `sb` 0x12345678 at 0x11, then `lw` 0x10 → 0xDEAD78EF. Then `sh` 0xAAAA5555 at 0x12, then `lw` → 0x555578EF.
- **Errors:**
  - `lw` at 0x02 → `err`=1, `rdata`=0.
  - memop 011 → `err`=1.
  - `sw` to word index `DEPTH_WORDS` → `err`=1, and a subsequent `lw` at 0x0 shows unchanged data.
- **Wait states:** `WAIT_CYCLES`=3 with `req` held high for two requests.
  - Required: `ack` at E+4 for each request; `busy` high for 4 cycles; one idle cycle between transactions.
  - Inputs changed while `busy` are ignored.
- **Reset mid-request:** with `WAIT_CYCLES`=3, accept `sw` 0x11111111 at 0x20 and assert `rst_n`=0 during WAIT.
  - Required: outputs go to 0 immediately; no `ack`.
  - After release, `lw` 0x20 returns the prior contents.
